// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle CPU control FSM:
// phase states, instruction classes, opcode/funct values and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // One-hot datapath select encodings; all-zero means "not used this cycle".
    localparam logic [1:0] LORD_NONE       = 2'b00;
    localparam logic [1:0] LORD_PC         = 2'b01;
    localparam logic [1:0] LORD_ALUOUT     = 2'b10;
    localparam logic [1:0] REGDST_NONE     = 2'b00;
    localparam logic [1:0] REGDST_RT       = 2'b01;
    localparam logic [1:0] REGDST_RD       = 2'b10;
    localparam logic [1:0] MEMTOREG_NONE   = 2'b00;
    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b01;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b10;
    localparam logic [1:0] SRCA_NONE       = 2'b00;
    localparam logic [1:0] SRCA_PC         = 2'b01;
    localparam logic [1:0] SRCA_A          = 2'b10;
    localparam logic [3:0] SRCB_NONE       = 4'b0000;
    localparam logic [3:0] SRCB_B          = 4'b0001;
    localparam logic [3:0] SRCB_FOUR       = 4'b0010;
    localparam logic [3:0] SRCB_BRANCH     = 4'b0100;
    localparam logic [3:0] SRCB_IMM        = 4'b1000;
    localparam logic [2:0] PCSRC_NONE      = 3'b000;
    localparam logic [2:0] PCSRC_ALU       = 3'b001;
    localparam logic [2:0] PCSRC_ALUOUT    = 3'b010;
    localparam logic [2:0] PCSRC_JUMP      = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic [4:0] phase_onehot(input state_t s);
        case (s)
            ST_IF:   return 5'b00001;
            ST_ID:   return 5'b00010;
            ST_EX:   return 5'b00100;
            ST_MEM:  return 5'b01000;
            ST_WB:   return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the control FSM (master) and the datapath (slave):
// IR fields and flags in, mux selects, strobes and status out.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       irfunc;
    logic             zero;
    logic             mem_ready;
    logic [4:0]       p;
    logic [1:0]       lorD;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic [1:0]       AluSrcA;
    logic [3:0]       AluSrcB;
    logic [2:0]       PCSource;
    logic [2:0]       alu_op;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic             reg_we;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic             trap;
    logic [1:0]       trap_cause;

    modport master (
        input  op, irfunc, zero, mem_ready,
        output p, lorD, RegDst, MemtoReg, AluSrcA, AluSrcB, PCSource, alu_op,
        output mem_req, mem_we, ir_we, pc_we, reg_we, retire,
        output retired_cnt, trap, trap_cause
    );

    modport slave (
        output op, irfunc, zero, mem_ready,
        input  p, lorD, RegDst, MemtoReg, AluSrcA, AluSrcB, PCSource, alu_op,
        input  mem_req, mem_we, ir_we, pc_we, reg_we, retire,
        input  retired_cnt, trap, trap_cause
    );
endinterface

// File: rtl/mc_instr_decode.sv
// Combinational instruction classifier: maps op/irfunc to an instruction class,
// the R-type ALU operation and an illegal-encoding flag.
module mc_instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   irfunc,
    output instr_class_t instr_class,
    output logic [2:0]   r_alu_op,
    output logic         illegal
);

    // Unknown opcodes and unknown R-type functs both fall through to CLS_ILLEGAL.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        r_alu_op    = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                instr_class = CLS_RTYPE;
                case (irfunc)
                    FN_ADD:  r_alu_op = ALU_ADD;
                    FN_SUB:  r_alu_op = ALU_SUB;
                    FN_AND:  r_alu_op = ALU_AND;
                    FN_OR:   r_alu_op = ALU_OR;
                    FN_SLT:  r_alu_op = ALU_SLT;
                    default: instr_class = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: instr_class = CLS_ADDI;
            OP_LW:   instr_class = CLS_LW;
            OP_SW:   instr_class = CLS_SW;
            OP_BEQ:  instr_class = CLS_BEQ;
            OP_J:    instr_class = CLS_J;
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EX/MEM/WB, drives datapath selects
// and strobes, handles memory wait timeout, sticky trap and retired-instruction count.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    mc_control_fsm_if.master bus
);

    localparam bit              TO_EN      = (MEM_TIMEOUT != 0);
    localparam int              TO_LIMIT_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TO_LIMIT_I);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [1:0]       trap_cause_q, trap_cause_d;

    instr_class_t instr_class;
    logic [2:0]   r_alu_op;
    logic         illegal;

    logic       waiting, timeout_hit;
    logic [1:0] lord_sel, reg_dst_sel, mem_to_reg_sel, src_a_sel;
    logic [3:0] src_b_sel;
    logic [2:0] pc_src_sel, alu_sel;
    logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, retire_c;

    mc_instr_decode u_decode (
        .op          (bus.op),
        .irfunc      (bus.irfunc),
        .instr_class (instr_class),
        .r_alu_op    (r_alu_op),
        .illegal     (illegal)
    );

    // The timeout fires on the stall cycle that would bring the counter to MEM_TIMEOUT.
    assign waiting     = ((state_q == ST_IF) || (state_q == ST_MEM)) && !bus.mem_ready;
    assign timeout_hit = TO_EN && waiting && (to_cnt_q == TO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IF;
            to_cnt_q      <= '0;
            retired_cnt_q <= '0;
            trap_cause_q  <= CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            retired_cnt_q <= retired_cnt_d;
            trap_cause_q  <= trap_cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        trap_cause_d   = trap_cause_q;
        lord_sel       = LORD_NONE;
        reg_dst_sel    = REGDST_NONE;
        mem_to_reg_sel = MEMTOREG_NONE;
        src_a_sel      = SRCA_NONE;
        src_b_sel      = SRCB_NONE;
        pc_src_sel     = PCSRC_NONE;
        alu_sel        = ALU_ADD;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        reg_we_c       = 1'b0;
        retire_c       = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_req_c  = 1'b1;
                lord_sel   = LORD_PC;
                src_a_sel  = SRCA_PC;
                src_b_sel  = SRCB_FOUR;
                pc_src_sel = PCSRC_ALU;
                if (bus.mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = ST_ID;
                end else if (timeout_hit) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_ID: begin
                src_a_sel = SRCA_PC;
                src_b_sel = SRCB_BRANCH;
                if (instr_class == CLS_J) begin
                    pc_we_c    = 1'b1;
                    pc_src_sel = PCSRC_JUMP;
                    retire_c   = 1'b1;
                    state_d    = ST_IF;
                end else if (illegal) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                src_a_sel = SRCA_A;
                case (instr_class)
                    CLS_RTYPE: begin
                        src_b_sel = SRCB_B;
                        alu_sel   = r_alu_op;
                        state_d   = ST_WB;
                    end
                    CLS_ADDI: begin
                        src_b_sel = SRCB_IMM;
                        state_d   = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        src_b_sel = SRCB_IMM;
                        state_d   = ST_MEM;
                    end
                    CLS_BEQ: begin
                        src_b_sel  = SRCB_B;
                        alu_sel    = ALU_SUB;
                        pc_src_sel = PCSRC_ALUOUT;
                        pc_we_c    = bus.zero;
                        retire_c   = 1'b1;
                        state_d    = ST_IF;
                    end
                    default: begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                lord_sel  = LORD_ALUOUT;
                mem_we_c  = (instr_class == CLS_SW);
                if (bus.mem_ready) begin
                    if (instr_class == CLS_SW) begin
                        retire_c = 1'b1;
                        state_d  = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = ST_IF;
                case (instr_class)
                    CLS_RTYPE: begin
                        reg_dst_sel    = REGDST_RD;
                        mem_to_reg_sel = MEMTOREG_ALUOUT;
                    end
                    CLS_LW: begin
                        reg_dst_sel    = REGDST_RT;
                        mem_to_reg_sel = MEMTOREG_MDR;
                    end
                    default: begin
                        reg_dst_sel    = REGDST_RT;
                        mem_to_reg_sel = MEMTOREG_ALUOUT;
                    end
                endcase
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase
    end

    // Wait counter saturates rather than wrapping so a disabled timeout never aliases back to zero.
    always_comb begin
        to_cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
        end
    end

    assign retired_cnt_d = retire_c ? retired_cnt_q + CNT_W'(1) : retired_cnt_q;

    assign bus.p           = phase_onehot(state_q);
    assign bus.lorD        = lord_sel;
    assign bus.RegDst      = reg_dst_sel;
    assign bus.MemtoReg    = mem_to_reg_sel;
    assign bus.AluSrcA     = src_a_sel;
    assign bus.AluSrcB     = src_b_sel;
    assign bus.PCSource    = pc_src_sel;
    assign bus.alu_op      = alu_sel;
    assign bus.mem_req     = mem_req_c & ~rst;
    assign bus.mem_we      = mem_we_c & ~rst;
    assign bus.ir_we       = ir_we_c & ~rst;
    assign bus.pc_we       = pc_we_c & ~rst;
    assign bus.reg_we      = reg_we_c & ~rst;
    assign bus.retire      = retire_c & ~rst;
    assign bus.retired_cnt = retired_cnt_q;
    assign bus.trap        = (state_q == ST_TRAP);
    assign bus.trap_cause  = trap_cause_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: walks each instruction class cycle by cycle
// against hand-computed phase, select and strobe values, plus reset, trap and wrap cases.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_NONE  = 6'b000000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    int               compared = 0;
    int               mismatched = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic [5:0]       strobes;
    logic [17:0]      sels;

    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(
        .CNT_W       (CNT_W),
        .TO_W        (8),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign strobes = {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.reg_we, bus.retire};
    assign sels    = {bus.lorD, bus.RegDst, bus.MemtoReg, bus.AluSrcA, bus.AluSrcB, bus.PCSource, bus.alu_op};

    // One call is one clock cycle: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        @(negedge clk);
        bus.op        = o;
        bus.irfunc    = f;
        bus.zero      = z;
        bus.mem_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.op        = OP_R;
        bus.irfunc    = F_ADD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.op        = OP_R;
        bus.irfunc    = F_ADD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        compared++; if (bus.p !== 5'b00001) begin mismatched++; $display("[TB] FAIL reset_p: got %b expected 00001", bus.p); end
        compared++; if (strobes !== 6'b000000) begin mismatched++; $display("[TB] FAIL reset_strobes: got %b expected 000000", strobes); end
        compared++; if (sels !== {2'b01, 2'b00, 2'b00, 2'b01, 4'b0010, 3'b001, 3'b000}) begin mismatched++; $display("[TB] FAIL reset_sels: got %b", sels); end
        compared++; if (bus.retired_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.retired_cnt); end
        compared++; if ({bus.trap, bus.trap_cause} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_trap: got %b expected 000", {bus.trap, bus.trap_cause}); end
        @(posedge clk);
        #2 rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_add();
        logic [4:0]  ep [4];
        logic [5:0]  es [4];
        logic [17:0] el [4];
        ep = '{5'b00001, 5'b00010, 5'b00100, 5'b10000};
        es = '{6'b101100, 6'b000000, 6'b000000, 6'b000011};
        el = '{{2'b01, 2'b00, 2'b00, 2'b01, 4'b0010, 3'b001, 3'b000},
               {2'b00, 2'b00, 2'b00, 2'b01, 4'b0100, 3'b000, 3'b000},
               {2'b00, 2'b00, 2'b00, 2'b10, 4'b0001, 3'b000, 3'b000},
               {2'b00, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 3'b000}};
        for (int i = 0; i < 4; i++) begin
            drive(OP_R, F_ADD, 1'b0, 1'b1);
            compared++; if (bus.p !== ep[i]) begin mismatched++; $display("[TB] FAIL add_p[%0d]: got %b expected %b", i, bus.p, ep[i]); end
            compared++; if (strobes !== es[i]) begin mismatched++; $display("[TB] FAIL add_strobes[%0d]: got %b expected %b", i, strobes, es[i]); end
            compared++; if (sels !== el[i]) begin mismatched++; $display("[TB] FAIL add_sels[%0d]: got %b expected %b", i, sels, el[i]); end
            compared++; if (bus.retired_cnt !== exp_cnt) begin mismatched++; $display("[TB] FAIL add_cnt[%0d]: got %0d expected %0d", i, bus.retired_cnt, exp_cnt); end
        end
        exp_cnt = exp_cnt + 1'b1;
        drive(OP_R, F_ADD, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.retired_cnt} !== {5'b00001, exp_cnt}) begin mismatched++; $display("[TB] FAIL add_done: got p=%b cnt=%0d expected p=00001 cnt=%0d", bus.p, bus.retired_cnt, exp_cnt); end
    endtask

    task automatic test_alu_funcs();
        logic [5:0] fn [5];
        logic [2:0] ea [5];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ea = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            drive(OP_R, fn[i], 1'b0, 1'b1);
            drive(OP_R, fn[i], 1'b0, 1'b1);
            drive(OP_R, fn[i], 1'b0, 1'b1);
            compared++; if ({bus.p, bus.AluSrcA, bus.AluSrcB, bus.alu_op} !== {5'b00100, 2'b10, 4'b0001, ea[i]}) begin mismatched++; $display("[TB] FAIL alu_ex[%0d]: got p=%b a=%b b=%b op=%b expected alu op %b", i, bus.p, bus.AluSrcA, bus.AluSrcB, bus.alu_op, ea[i]); end
            drive(OP_R, fn[i], 1'b0, 1'b1);
            compared++; if ({bus.reg_we, bus.retire} !== 2'b11) begin mismatched++; $display("[TB] FAIL alu_wb[%0d]: got %b expected 11", i, {bus.reg_we, bus.retire}); end
            exp_cnt = exp_cnt + 1'b1;
        end
        drive(OP_R, F_ADD, 1'b0, 1'b0);
        compared++; if (bus.retired_cnt !== exp_cnt) begin mismatched++; $display("[TB] FAIL alu_cnt: got %0d expected %0d", bus.retired_cnt, exp_cnt); end
    endtask

    task automatic test_lw_stall();
        drive(OP_LW, F_NONE, 1'b0, 1'b1);
        drive(OP_LW, F_NONE, 1'b0, 1'b1);
        drive(OP_LW, F_NONE, 1'b0, 1'b1);
        compared++; if ({bus.AluSrcA, bus.AluSrcB, bus.alu_op} !== {2'b10, 4'b1000, 3'b000}) begin mismatched++; $display("[TB] FAIL lw_ex: got a=%b b=%b op=%b", bus.AluSrcA, bus.AluSrcB, bus.alu_op); end
        for (int k = 0; k < 4; k++) begin
            drive(OP_LW, F_NONE, 1'b0, (k == 3));
            compared++; if ({bus.p, bus.lorD, bus.mem_req, bus.mem_we} !== {5'b01000, 2'b10, 1'b1, 1'b0}) begin mismatched++; $display("[TB] FAIL lw_mem[%0d]: got p=%b lorD=%b req=%b we=%b", k, bus.p, bus.lorD, bus.mem_req, bus.mem_we); end
        end
        drive(OP_LW, F_NONE, 1'b0, 1'b1);
        compared++; if ({bus.p, bus.RegDst, bus.MemtoReg, bus.reg_we, bus.retire} !== {5'b10000, 2'b01, 2'b10, 1'b1, 1'b1}) begin mismatched++; $display("[TB] FAIL lw_wb: got p=%b dst=%b m2r=%b we=%b ret=%b", bus.p, bus.RegDst, bus.MemtoReg, bus.reg_we, bus.retire); end
        exp_cnt = exp_cnt + 1'b1;
        drive(OP_LW, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.retired_cnt} !== {5'b00001, exp_cnt}) begin mismatched++; $display("[TB] FAIL lw_done: got p=%b cnt=%0d expected cnt=%0d", bus.p, bus.retired_cnt, exp_cnt); end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            automatic logic z = (k == 0);
            drive(OP_BEQ, F_NONE, z, 1'b1);
            drive(OP_BEQ, F_NONE, z, 1'b1);
            compared++; if (bus.pc_we !== 1'b0) begin mismatched++; $display("[TB] FAIL beq_id_pcwe[%0d]: got %b expected 0", k, bus.pc_we); end
            drive(OP_BEQ, F_NONE, z, 1'b1);
            compared++; if ({bus.p, bus.PCSource, bus.pc_we, bus.retire, bus.alu_op, bus.AluSrcA, bus.AluSrcB} !== {5'b00100, 3'b010, z, 1'b1, 3'b001, 2'b10, 4'b0001}) begin mismatched++; $display("[TB] FAIL beq_ex[%0d]: got p=%b pcsrc=%b pcwe=%b ret=%b op=%b expected pcwe=%b", k, bus.p, bus.PCSource, bus.pc_we, bus.retire, bus.alu_op, z); end
            exp_cnt = exp_cnt + 1'b1;
            drive(OP_BEQ, F_NONE, z, 1'b0);
            compared++; if ({bus.p, bus.retired_cnt} !== {5'b00001, exp_cnt}) begin mismatched++; $display("[TB] FAIL beq_done[%0d]: got p=%b cnt=%0d expected cnt=%0d", k, bus.p, bus.retired_cnt, exp_cnt); end
        end
    endtask

    task automatic test_jump();
        drive(OP_J, F_NONE, 1'b0, 1'b1);
        drive(OP_J, F_NONE, 1'b0, 1'b1);
        compared++; if ({bus.p, bus.PCSource, bus.pc_we, bus.retire} !== {5'b00010, 3'b100, 1'b1, 1'b1}) begin mismatched++; $display("[TB] FAIL j_id: got p=%b pcsrc=%b pcwe=%b ret=%b", bus.p, bus.PCSource, bus.pc_we, bus.retire); end
        exp_cnt = exp_cnt + 1'b1;
        drive(OP_J, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.retired_cnt} !== {5'b00001, exp_cnt}) begin mismatched++; $display("[TB] FAIL j_done: got p=%b cnt=%0d expected cnt=%0d", bus.p, bus.retired_cnt, exp_cnt); end
    endtask

    task automatic test_sw_reset();
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        compared++; if ({bus.p, bus.mem_req, bus.mem_we, bus.retire, bus.lorD} !== {5'b01000, 1'b1, 1'b1, 1'b1, 2'b10}) begin mismatched++; $display("[TB] FAIL sw_mem: got p=%b req=%b we=%b ret=%b lorD=%b", bus.p, bus.mem_req, bus.mem_we, bus.retire, bus.lorD); end
        exp_cnt = exp_cnt + 1'b1;
        drive(OP_SW, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.retired_cnt} !== {5'b00001, exp_cnt}) begin mismatched++; $display("[TB] FAIL sw_done: got p=%b cnt=%0d expected cnt=%0d", bus.p, bus.retired_cnt, exp_cnt); end
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        drive(OP_SW, F_NONE, 1'b0, 1'b1);
        drive(OP_SW, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.mem_we, bus.retire} !== {5'b01000, 1'b1, 1'b0}) begin mismatched++; $display("[TB] FAIL sw_stall: got p=%b we=%b ret=%b", bus.p, bus.mem_we, bus.retire); end
        #2 rst = 1'b1;
        #1;
        compared++; if ({bus.p, strobes, bus.retired_cnt} !== {5'b00001, 6'b000000, 4'd0}) begin mismatched++; $display("[TB] FAIL sw_async_rst: got p=%b strobes=%b cnt=%0d", bus.p, strobes, bus.retired_cnt); end
        @(posedge clk);
        #2 rst = 1'b0;
        exp_cnt = '0;
        drive(OP_SW, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.retired_cnt, bus.trap} !== {5'b00001, 4'd0, 1'b0}) begin mismatched++; $display("[TB] FAIL sw_after_rst: got p=%b cnt=%0d trap=%b", bus.p, bus.retired_cnt, bus.trap); end
    endtask

    task automatic test_cnt_wrap();
        for (int i = 0; i < 16; i++) begin
            drive(OP_J, F_NONE, 1'b0, 1'b1);
            drive(OP_J, F_NONE, 1'b0, 1'b1);
            compared++; if ({bus.retire, bus.retired_cnt} !== {1'b1, exp_cnt}) begin mismatched++; $display("[TB] FAIL wrap_id[%0d]: got ret=%b cnt=%0d expected cnt=%0d", i, bus.retire, bus.retired_cnt, exp_cnt); end
            exp_cnt = exp_cnt + 1'b1;
        end
        drive(OP_J, F_NONE, 1'b0, 1'b0);
        compared++; if (bus.retired_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL wrap_zero: got %0d expected 0", bus.retired_cnt); end
    endtask

    task automatic test_illegal();
        drive(OP_BAD, F_NONE, 1'b0, 1'b1);
        drive(OP_BAD, F_NONE, 1'b0, 1'b1);
        compared++; if ({bus.p, bus.trap} !== {5'b00010, 1'b0}) begin mismatched++; $display("[TB] FAIL ill_id: got p=%b trap=%b", bus.p, bus.trap); end
        for (int k = 0; k < 3; k++) begin
            drive(OP_BAD, F_NONE, 1'b1, 1'b1);
            compared++; if ({bus.p, bus.trap, bus.trap_cause, strobes} !== {5'b00000, 1'b1, 2'b01, 6'b000000}) begin mismatched++; $display("[TB] FAIL ill_trap[%0d]: got p=%b trap=%b cause=%b strobes=%b", k, bus.p, bus.trap, bus.trap_cause, strobes); end
        end
        do_reset();
        drive(OP_R, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.trap, bus.trap_cause} !== {5'b00001, 1'b0, 2'b00}) begin mismatched++; $display("[TB] FAIL ill_cleared: got p=%b trap=%b cause=%b", bus.p, bus.trap, bus.trap_cause); end
        drive(OP_R, F_NONE, 1'b0, 1'b1);
        drive(OP_R, F_NONE, 1'b0, 1'b1);
        drive(OP_R, F_NONE, 1'b0, 1'b1);
        compared++; if ({bus.p, bus.trap, bus.trap_cause} !== {5'b00000, 1'b1, 2'b01}) begin mismatched++; $display("[TB] FAIL ill_funct: got p=%b trap=%b cause=%b", bus.p, bus.trap, bus.trap_cause); end
        do_reset();
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 3; k++) begin
            drive(OP_J, F_NONE, 1'b0, 1'b0);
            compared++; if ({bus.p, bus.ir_we, bus.trap} !== {5'b00001, 1'b0, 1'b0}) begin mismatched++; $display("[TB] FAIL to_short[%0d]: got p=%b irwe=%b trap=%b", k, bus.p, bus.ir_we, bus.trap); end
        end
        drive(OP_J, F_NONE, 1'b0, 1'b1);
        compared++; if (bus.ir_we !== 1'b1) begin mismatched++; $display("[TB] FAIL to_fetch: got irwe=%b expected 1", bus.ir_we); end
        drive(OP_J, F_NONE, 1'b0, 1'b0);
        compared++; if ({bus.p, bus.retire} !== {5'b00010, 1'b1}) begin mismatched++; $display("[TB] FAIL to_j: got p=%b ret=%b", bus.p, bus.retire); end
        for (int k = 0; k < 4; k++) begin
            drive(OP_J, F_NONE, 1'b0, 1'b0);
            compared++; if ({bus.p, bus.ir_we, bus.trap} !== {5'b00001, 1'b0, 1'b0}) begin mismatched++; $display("[TB] FAIL to_stall[%0d]: got p=%b irwe=%b trap=%b", k, bus.p, bus.ir_we, bus.trap); end
        end
        for (int k = 0; k < 3; k++) begin
            drive(OP_J, F_NONE, 1'b0, (k != 0));
            compared++; if ({bus.p, bus.trap, bus.trap_cause, strobes} !== {5'b00000, 1'b1, 2'b10, 6'b000000}) begin mismatched++; $display("[TB] FAIL to_trap[%0d]: got p=%b trap=%b cause=%b strobes=%b", k, bus.p, bus.trap, bus.trap_cause, strobes); end
        end
    endtask

    initial begin
        $display("[TB] starting mc_control_fsm directed tests");
        test_reset();
        test_add();
        test_alu_funcs();
        test_lw_stall();
        test_beq();
        test_jump();
        test_sw_reset();
        test_cnt_wrap();
        test_illegal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
